dbg_ram_responder: RTL and testbench

- Slave-side responder for the debug-module window (byte offsets 0x000–0x0FF after the mux subtracts the 0x700 base).
- Serves two request/grant/rvalid initiator ports (instruction fetch and data) from one shared single-port word RAM.
- Arbitrates between the ports, inserts programmable wait states before grant, and returns one rvalid per granted request.
- Sits directly behind the core's instruction/data address mux, on its debug-side outputs.

---
 rtl/mem_pkg.sv | 11 +
 rtl/dbg_ram_responder_if.sv | 51 +++++
 rtl/dbg_ram_array.sv | 28 ++
 rtl/dbg_ram_responder.sv | 169 ++++++++++++++++
 tb/tb_dbg_ram_responder.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants and FSM/owner types for the debug-window RAM responder.
package mem_pkg;

  localparam logic [31:0] DBG_BASE  = 32'h0000_0700;
  localparam logic [31:0] DBG_SIZE  = 32'h0000_0100;
  localparam logic [31:0] MAIN_BASE = 32'h1000_0000;

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {OWN_INSTR, OWN_DATA} owner_t;

endpackage

// File: rtl/dbg_ram_responder_if.sv
// Request/grant/rvalid bundle for the fetch and data ports of the debug RAM.
// Error flags exist only when DBG_RAM_ERR_EN is defined.
interface dbg_ram_responder_if;

  logic        instr_req_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
`ifdef DBG_RAM_ERR_EN
  logic        instr_err_o;
  logic        data_err_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );
`else
  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o
  );
`endif

endinterface

// File: rtl/dbg_ram_array.sv
// Single-port DEPTH x 32 word RAM: synchronous read, per-byte write enables, no reset.
module dbg_ram_array #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) r_mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_o <= r_mem[addr_i];
    end
  end

endmodule

// File: rtl/dbg_ram_responder.sv
// Two-port (fetch/data) responder for the debug window over one shared word RAM.
// Round-robin arbitration, WAIT_CYCLES wait states before gnt; DBG_RAM_ERR_EN adds range errors.
module dbg_ram_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dbg_ram_responder_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(WAIT_CYCLES + 2);

  state_t        r_state, w_state_nxt;
  owner_t        r_owner, w_owner_nxt;
  owner_t        r_rr, w_rr_nxt;
  logic          r_contest, w_contest_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic          w_ireq, w_dreq, w_both, w_owner_req;
  owner_t        w_win;
  logic          w_fire;
  owner_t        w_fire_own;

  logic          w_ram_en, w_ram_we;
  logic [3:0]    w_ram_be;
  logic [AW-1:0] w_ram_addr;
  logic [31:0]   w_ram_rdata;
  logic          w_instr_oor, w_data_oor;

  logic          r_instr_rvalid, r_data_rvalid;
  logic          r_instr_zero, r_data_zero;
  logic          r_instr_err, r_data_err;
  logic [31:0]   r_instr_hold, r_data_hold;
  logic [31:0]   w_instr_rdata, w_data_rdata;

  assign w_ireq = bus.instr_req_i;
  assign w_dreq = bus.data_req_i;
  assign w_both = w_ireq & w_dreq;
  // On conflict the port that did not win the previous conflict goes first.
  assign w_win  = (w_dreq && (!w_ireq || r_rr == OWN_INSTR)) ? OWN_DATA : OWN_INSTR;
  assign w_owner_req = (r_owner == OWN_DATA) ? w_dreq : w_ireq;

`ifdef DBG_RAM_ERR_EN
  assign w_instr_oor = |bus.instr_addr_i[31:AW+2];
  assign w_data_oor  = |bus.data_addr_i[31:AW+2];
`else
  assign w_instr_oor = 1'b0;
  assign w_data_oor  = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_owner   <= OWN_INSTR;
      r_rr      <= OWN_INSTR;
      r_contest <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_rr      <= w_rr_nxt;
      r_contest <= w_contest_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_rr_nxt      = r_rr;
    w_contest_nxt = r_contest;
    w_cnt_nxt     = r_cnt;
    w_fire        = 1'b0;
    w_fire_own    = r_owner;
    case (r_state)
      IDLE: begin
        if (w_ireq || w_dreq) begin
          if (WAIT_CYCLES == 0) begin
            w_fire     = 1'b1;
            w_fire_own = w_win;
            if (w_both) w_rr_nxt = w_win;
          end else begin
            w_state_nxt   = WAIT;
            w_owner_nxt   = w_win;
            w_contest_nxt = w_both;
            w_cnt_nxt     = CW'(1);
          end
        end
      end
      WAIT: begin
        // Owner abandoning its request is dropped silently.
        if (!w_owner_req) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(WAIT_CYCLES)) begin
          w_fire      = 1'b1;
          w_fire_own  = r_owner;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          if (r_contest) w_rr_nxt = r_owner;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.instr_gnt_o = w_fire && (w_fire_own == OWN_INSTR);
    bus.data_gnt_o  = w_fire && (w_fire_own == OWN_DATA);
    w_ram_en        = w_fire;
    w_ram_we        = bus.data_gnt_o && bus.data_we_i && !w_data_oor;
    w_ram_be        = bus.data_be_i;
    w_ram_addr      = (w_fire_own == OWN_DATA) ? bus.data_addr_i[AW+1:2]
                                               : bus.instr_addr_i[AW+1:2];
  end

  dbg_ram_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk_i   (clk_i),
    .en_i    (w_ram_en),
    .we_i    (w_ram_we),
    .be_i    (w_ram_be),
    .addr_i  (w_ram_addr),
    .wdata_i (bus.data_wdata_i),
    .rdata_o (w_ram_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_instr_rvalid <= 1'b0;
      r_data_rvalid  <= 1'b0;
      r_instr_zero   <= 1'b0;
      r_data_zero    <= 1'b0;
      r_instr_err    <= 1'b0;
      r_data_err     <= 1'b0;
      r_instr_hold   <= '0;
      r_data_hold    <= '0;
    end else begin
      r_instr_rvalid <= bus.instr_gnt_o;
      r_data_rvalid  <= bus.data_gnt_o;
      r_instr_zero   <= bus.instr_gnt_o && w_instr_oor;
      r_data_zero    <= bus.data_gnt_o && (bus.data_we_i || w_data_oor);
      r_instr_err    <= bus.instr_gnt_o && w_instr_oor;
      r_data_err     <= bus.data_gnt_o && w_data_oor;
      if (r_instr_rvalid) r_instr_hold <= w_instr_rdata;
      if (r_data_rvalid)  r_data_hold  <= w_data_rdata;
    end
  end

  // RAM output is only meaningful in the rvalid cycle; afterwards the held copy is shown.
  assign w_instr_rdata = r_instr_rvalid ? (r_instr_zero ? 32'h0 : w_ram_rdata) : r_instr_hold;
  assign w_data_rdata  = r_data_rvalid  ? (r_data_zero  ? 32'h0 : w_ram_rdata) : r_data_hold;

  assign bus.instr_rvalid_o = r_instr_rvalid;
  assign bus.data_rvalid_o  = r_data_rvalid;
  assign bus.instr_rdata_o  = w_instr_rdata;
  assign bus.data_rdata_o   = w_data_rdata;

`ifdef DBG_RAM_ERR_EN
  assign bus.instr_err_o = r_instr_err;
  assign bus.data_err_o  = r_data_err;
`endif

endmodule

// File: tb/tb_dbg_ram_responder.sv
// Directed bench: three responders (WAIT_CYCLES 0/3/2) driven in a fixed sequence.
// Range-error checks apply when DBG_RAM_ERR_EN is defined, aliasing checks otherwise.
module tb_dbg_ram_responder;
  import mem_pkg::*;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  dbg_ram_responder_if b0();
  dbg_ram_responder_if b3();
  dbg_ram_responder_if b2();

  dbg_ram_responder #(.DEPTH(64), .WAIT_CYCLES(0)) d0 (.clk_i(clk), .rst_i(rst), .bus(b0));
  dbg_ram_responder #(.DEPTH(64), .WAIT_CYCLES(3)) d3 (.clk_i(clk), .rst_i(rst), .bus(b3));
  dbg_ram_responder #(.DEPTH(64), .WAIT_CYCLES(2)) d2 (.clk_i(clk), .rst_i(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    b0.instr_req_i = 0; b0.instr_addr_i = 0; b0.data_req_i = 0; b0.data_we_i = 0;
    b0.data_be_i = 0; b0.data_addr_i = 0; b0.data_wdata_i = 0;
    b3.instr_req_i = 0; b3.instr_addr_i = 0; b3.data_req_i = 0; b3.data_we_i = 0;
    b3.data_be_i = 0; b3.data_addr_i = 0; b3.data_wdata_i = 0;
    b2.instr_req_i = 0; b2.instr_addr_i = 0; b2.data_req_i = 0; b2.data_we_i = 0;
    b2.data_be_i = 0; b2.data_addr_i = 0; b2.data_wdata_i = 0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_igt",    32'(b0.instr_gnt_o), 32'd0);
    chk("rst_dgt",    32'(b0.data_gnt_o), 32'd0);
    chk("rst_irv",    32'(b0.instr_rvalid_o), 32'd0);
    chk("rst_drv",    32'(b0.data_rvalid_o), 32'd0);
    chk("rst_irdata", b0.instr_rdata_o, 32'h0);
    chk("rst_drdata", b0.data_rdata_o, 32'h0);
    chk("rst_state",  32'(d3.r_state), 32'(IDLE));
    rst = 1'b0;

    // First conflict: data wins, instr next cycle
    @(negedge clk);
    b0.instr_req_i = 1; b0.instr_addr_i = 32'h0;
    b0.data_req_i = 1; b0.data_we_i = 0; b0.data_addr_i = 32'h4;
    #1 chk("b1_dgt", 32'(b0.data_gnt_o), 32'd1);
    chk("b1_igt", 32'(b0.instr_gnt_o), 32'd0);
    @(negedge clk); b0.data_req_i = 0;
    #1 chk("b1_igt2", 32'(b0.instr_gnt_o), 32'd1);
    chk("b1_drv", 32'(b0.data_rvalid_o), 32'd1);
    chk("b1_irv0", 32'(b0.instr_rvalid_o), 32'd0);
    @(negedge clk); b0.instr_req_i = 0;
    #1 chk("b1_irv", 32'(b0.instr_rvalid_o), 32'd1);
    chk("b1_drv0", 32'(b0.data_rvalid_o), 32'd0);

    // Second conflict: instr wins
    @(negedge clk); b0.instr_req_i = 1; b0.data_req_i = 1;
    #1 chk("b2_igt", 32'(b0.instr_gnt_o), 32'd1);
    chk("b2_dgt", 32'(b0.data_gnt_o), 32'd0);
    @(negedge clk); b0.instr_req_i = 0;
    #1 chk("b2_dgt2", 32'(b0.data_gnt_o), 32'd1);
    chk("b2_irv", 32'(b0.instr_rvalid_o), 32'd1);
    @(negedge clk); b0.data_req_i = 0;
    #1 chk("b2_drv", 32'(b0.data_rvalid_o), 32'd1);
    chk("b2_igt0", 32'(b0.instr_gnt_o), 32'd0);

    // Byte-enable write then read-back, back-to-back grants
    @(negedge clk);
    b0.data_req_i = 1; b0.data_we_i = 1; b0.data_be_i = 4'hF;
    b0.data_addr_i = 32'h10; b0.data_wdata_i = 32'h1122_3344;
    #1 chk("wr1_gnt", 32'(b0.data_gnt_o), 32'd1);
    @(negedge clk); b0.data_be_i = 4'b0101; b0.data_wdata_i = 32'hDEAD_BEEF;
    #1 chk("wr2_gnt", 32'(b0.data_gnt_o), 32'd1);
    chk("wr1_rv", 32'(b0.data_rvalid_o), 32'd1);
    chk("wr1_rdata", b0.data_rdata_o, 32'h0);
    @(negedge clk); b0.data_we_i = 0;
    #1 chk("rd_gnt", 32'(b0.data_gnt_o), 32'd1);
    chk("wr2_rv", 32'(b0.data_rvalid_o), 32'd1);
    @(negedge clk); b0.data_req_i = 0; b0.instr_req_i = 1; b0.instr_addr_i = 32'h13;
    #1 chk("rd_rv", 32'(b0.data_rvalid_o), 32'd1);
    chk("rd_rdata", b0.data_rdata_o, 32'h11AD_33EF);
    chk("if_gnt", 32'(b0.instr_gnt_o), 32'd1);
    @(negedge clk); b0.instr_req_i = 0;
    #1 chk("if_rv", 32'(b0.instr_rvalid_o), 32'd1);
    chk("if_rdata", b0.instr_rdata_o, 32'h11AD_33EF);
    chk("rd_hold", b0.data_rdata_o, 32'h11AD_33EF);
    chk("rd_rv0", 32'(b0.data_rvalid_o), 32'd0);
    @(negedge clk);
    #1 chk("if_hold", b0.instr_rdata_o, 32'h11AD_33EF);

    // Out-of-range write at 0x100 (error or alias onto word 0)
    @(negedge clk);
    b0.data_req_i = 1; b0.data_we_i = 1; b0.data_be_i = 4'hF;
    b0.data_addr_i = 32'h0; b0.data_wdata_i = 32'h0102_0304;
    #1 chk("oor_w0_gnt", 32'(b0.data_gnt_o), 32'd1);
    @(negedge clk); b0.data_addr_i = 32'h100; b0.data_wdata_i = 32'hCAFE_F00D;
    #1 chk("oor_w1_gnt", 32'(b0.data_gnt_o), 32'd1);
    @(negedge clk); b0.data_we_i = 0; b0.data_addr_i = 32'h0;
    #1 chk("oor_rv", 32'(b0.data_rvalid_o), 32'd1);
`ifdef DBG_RAM_ERR_EN
    chk("oor_err", 32'(b0.data_err_o), 32'd1);
`endif
    chk("oor_wr_rdata", b0.data_rdata_o, 32'h0);
    @(negedge clk); b0.data_req_i = 0;
    #1 chk("oor_rd_rv", 32'(b0.data_rvalid_o), 32'd1);
`ifdef DBG_RAM_ERR_EN
    chk("oor_rd_err", 32'(b0.data_err_o), 32'd0);
    chk("oor_word0", b0.data_rdata_o, 32'h0102_0304);
`else
    chk("alias_word0", b0.data_rdata_o, 32'hCAFE_F00D);
`endif

    // WAIT_CYCLES = 3: instr at cycle 0, data from cycle 1
    @(negedge clk); b3.instr_req_i = 1; b3.instr_addr_i = 32'h10;
    #1 chk("w3_c0_igt", 32'(b3.instr_gnt_o), 32'd0);
    @(negedge clk); b3.data_req_i = 1; b3.data_we_i = 0; b3.data_addr_i = 32'h0;
    #1 chk("w3_c1_gnt", 32'({b3.instr_gnt_o, b3.data_gnt_o}), 32'd0);
    @(negedge clk);
    #1 chk("w3_c2_gnt", 32'({b3.instr_gnt_o, b3.data_gnt_o}), 32'd0);
    @(negedge clk);
    #1 chk("w3_c3_igt", 32'(b3.instr_gnt_o), 32'd1);
    chk("w3_c3_dgt", 32'(b3.data_gnt_o), 32'd0);
    @(negedge clk); b3.instr_req_i = 0;
    #1 chk("w3_c4_irv", 32'(b3.instr_rvalid_o), 32'd1);
    chk("w3_c4_dgt", 32'(b3.data_gnt_o), 32'd0);
    for (int c = 5; c < 7; c++) begin
      @(negedge clk);
      #1 chk($sformatf("w3_c%0d_dgt", c), 32'(b3.data_gnt_o), 32'd0);
    end
    @(negedge clk);
    #1 chk("w3_c7_dgt", 32'(b3.data_gnt_o), 32'd1);
    @(negedge clk); b3.data_req_i = 0;
    #1 chk("w3_c8_drv", 32'(b3.data_rvalid_o), 32'd1);
    chk("w3_c8_dgt", 32'(b3.data_gnt_o), 32'd0);

    // WAIT_CYCLES = 2: owner drops request mid-wait
    @(negedge clk); b2.instr_req_i = 1;
    #1 chk("w2_c0_igt", 32'(b2.instr_gnt_o), 32'd0);
    @(negedge clk); b2.instr_req_i = 0;
    #1 chk("w2_c1_igt", 32'(b2.instr_gnt_o), 32'd0);
    @(negedge clk);
    #1 chk("w2_c2_state", 32'(d2.r_state), 32'(IDLE));
    chk("w2_c2_irv", 32'(b2.instr_rvalid_o), 32'd0);
    chk("w2_c2_igt", 32'(b2.instr_gnt_o), 32'd0);
    @(negedge clk);
    #1 chk("w2_c3_irv", 32'(b2.instr_rvalid_o), 32'd0);

    // Reset in the cycle after a grant kills the pending rvalid
    @(negedge clk); b0.data_req_i = 1; b0.data_we_i = 0; b0.data_addr_i = 32'h10;
    #1 chk("rs_gnt", 32'(b0.data_gnt_o), 32'd1);
    @(negedge clk); b0.data_req_i = 0; rst = 1'b1;
    #1 chk("rs_drv", 32'(b0.data_rvalid_o), 32'd0);
    chk("rs_drdata", b0.data_rdata_o, 32'h0);
    chk("rs_irdata", b0.instr_rdata_o, 32'h0);
    chk("rs_dgt", 32'(b0.data_gnt_o), 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("rs_drv2", 32'(b0.data_rvalid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
